// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides the clock into digit slots of TICKS_PER_DIGIT enabled
// cycles. Each slot starts with BLANK_TICKS cycles of all anodes off, which
// suppresses ghosting while segments switch. Digit codes are captured into
// shadow registers once per frame, at the start of digit 1's slot, so that a
// frame never mixes old and new digit values.
//
// Ports
//   iClk          : clock, rising edge
//   iReset        : synchronous active-high reset
//   iCE           : clock enable; when low, all state and outputs hold
//   ivDisplay1..4 : digit codes, 0-9 numerals, 10-15 blank
//   ovAnode       : active-low anode enables, bit0 = digit 1 .. bit3 = digit 4
//   ovSegments    : active-low segments {g,f,e,d,c,b,a}
//   oFrameStrobe  : one-cycle pulse following each shadow capture
// -----------------------------------------------------------------------------
module display_scan_driver #(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCE,
    input  logic [3:0] ivDisplay1,
    input  logic [3:0] ivDisplay2,
    input  logic [3:0] ivDisplay3,
    input  logic [3:0] ivDisplay4,
    output logic [3:0] ovAnode,
    output logic [6:0] ovSegments,
    output logic       oFrameStrobe
);

    localparam int              P_W     = $clog2(TICKS_PER_DIGIT);
    localparam logic [P_W-1:0]  P_LAST  = P_W'(TICKS_PER_DIGIT - 1);
    localparam logic [P_W-1:0]  P_BLANK = P_W'(BLANK_TICKS);

    // Reject parameter combinations that would break the blanking guarantee.
    generate
        if (TICKS_PER_DIGIT < 4) begin : g_bad_ticks
            $error("display_scan_driver: TICKS_PER_DIGIT must be >= 4");
        end
        if (BLANK_TICKS < 1 || BLANK_TICKS > TICKS_PER_DIGIT - 2) begin : g_bad_blank
            $error("display_scan_driver: BLANK_TICKS must be in 1..TICKS_PER_DIGIT-2");
        end
    endgenerate

    // 7-segment decode, active-low {g,f,e,d,c,b,a}; codes 10-15 blank.
    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [P_W-1:0] r_p;
    logic [1:0]     r_d;
    logic [3:0]     r_shadow [4];
    logic [3:0]     r_anode;
    logic [6:0]     r_segments;
    logic           r_strobe;

    logic           w_p_wrap;
    logic           w_capture;
    logic           w_blank;
    logic [3:0]     w_anode_next;
    logic [6:0]     w_seg_next;

    assign w_p_wrap  = (r_p == P_LAST);
    assign w_capture = iCE && (r_p == '0) && (r_d == 2'd0);
    assign w_blank   = (r_p < P_BLANK);

    // Outputs are computed from the current (pre-edge) p, d and shadow
    // state, giving one cycle of latency. Because every slot begins with at
    // least one blank cycle, the anode always passes through 1111 between
    // digits, so two anodes are never low together.
    always_comb begin
        w_anode_next = 4'b1111;
        if (!w_blank) begin
            w_anode_next[r_d] = 1'b0;
        end
    end

    assign w_seg_next = f_decode(r_shadow[r_d]);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_p         <= '0;
            r_d         <= 2'd0;
            r_shadow[0] <= 4'd10;
            r_shadow[1] <= 4'd10;
            r_shadow[2] <= 4'd10;
            r_shadow[3] <= 4'd10;
            r_anode     <= 4'b1111;
            r_segments  <= 7'h7F;
            r_strobe    <= 1'b0;
        end else if (iCE) begin
            r_p <= w_p_wrap ? '0 : r_p + 1'b1;
            if (w_p_wrap) begin
                r_d <= r_d + 2'd1;
            end
            if (w_capture) begin
                r_shadow[0] <= ivDisplay1;
                r_shadow[1] <= ivDisplay2;
                r_shadow[2] <= ivDisplay3;
                r_shadow[3] <= ivDisplay4;
            end
            r_anode    <= w_anode_next;
            r_segments <= w_seg_next;
            r_strobe   <= w_capture;
        end else begin
            // Everything else holds; the strobe is a pulse and must not
            // stretch across a stalled cycle.
            r_strobe <= 1'b0;
        end
    end

    assign ovAnode      = r_anode;
    assign ovSegments   = r_segments;
    assign oFrameStrobe = r_strobe;

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

    localparam int TPD   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * TPD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0;
    logic [3:0] anode;
    logic [6:0] segs;
    logic       strobe;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       st;
    } exp_t;

    exp_t sb[$];

    display_scan_driver #(
        .TICKS_PER_DIGIT(TPD),
        .BLANK_TICKS    (BLANK)
    ) dut (
        .iClk        (clk),
        .iReset      (rst),
        .iCE         (ce),
        .ivDisplay1  (d1),
        .ivDisplay2  (d2),
        .ivDisplay3  (d3),
        .ivDisplay4  (d4),
        .ovAnode     (anode),
        .ovSegments  (segs),
        .oFrameStrobe(strobe)
    );

    always #5 clk = ~clk;

    // Hand-written segment table, active-low {g..a}.
    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference: position within a 32-cycle frame, counted in enabled cycles.
    int         m_pos = 0;
    logic [3:0] m_sh [4];
    exp_t       m_out;

    task automatic step(input logic c_ce, input logic c_rst,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] e);
        int slot;
        int tick;
        @(negedge clk);
        ce = c_ce; rst = c_rst; d1 = a; d2 = b; d3 = c; d4 = e;
        if (c_rst) begin
            m_pos = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'd10;
            m_out = '{an: 4'b1111, seg: 7'h7F, st: 1'b0};
        end else if (c_ce) begin
            slot = m_pos / TPD;
            tick = m_pos % TPD;
            m_out.an  = (tick < BLANK) ? 4'b1111 : ~(4'b0001 << slot);
            m_out.seg = seg_of(m_sh[slot]);
            m_out.st  = (m_pos == 0);
            if (m_pos == 0) begin
                m_sh[0] = a; m_sh[1] = b; m_sh[2] = c; m_sh[3] = e;
            end
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_out.st = 1'b0;
        end
        sb.push_back(m_out);
    endtask

    task automatic run(input int n, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, a, b, c, e);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: one output word per clock, compared against the queue head.
    logic prev_st = 1'b0;
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            chk("anode",    {3'b0, anode}, {3'b0, ex.an});
            chk("segments", segs,          ex.seg);
            chk("strobe",   {6'b0, strobe}, {6'b0, ex.st});
            chk("one_anode_low", {6'b0, ($countones(~anode) <= 1)}, 7'd1);
            chk("strobe_not_back_to_back", {6'b0, (prev_st && strobe)}, 7'd0);
            prev_st = strobe;
        end
    end

    initial begin
        m_out = '{an: 4'b1111, seg: 7'h7F, st: 1'b0};
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd10;

        // Reset held with CE both low and high
        step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        step(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);

        // First frame 1,2,3,4 and most of the next
        run(FRAME + 12, 4'd1, 4'd2, 4'd3, 4'd4);
        // Change to 8s mid-frame: rest of frame still 1..4, next frame all 8
        run(FRAME - 12 + FRAME, 4'd8, 4'd8, 4'd8, 4'd8);

        // Blank codes and edge numerals
        run(FRAME + 4, 4'd10, 4'd15, 4'd0, 4'd9);

        // CE stall of 5 cycles mid-slot, then two full frames
        run(FRAME - 4 + 9, 4'd5, 4'd6, 4'd7, 4'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
        run(2 * FRAME, 4'd5, 4'd6, 4'd7, 4'd3);

        // Advance until digit 3 is lit, then reset mid-frame
        for (int i = 0; i < FRAME && m_pos != 2 * TPD + 5; i++)
            step(1'b1, 1'b0, 4'd2, 4'd0, 4'd1, 4'd9);
        step(1'b1, 1'b1, 4'd2, 4'd0, 4'd1, 4'd9);
        run(FRAME + 8, 4'd6, 4'd4, 4'd2, 4'd7);

        // Randomised CE, inputs and occasional reset
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
